// File: rtl/rx_serial_7e1_pkg.sv
// Shared definitions for the 7E1 serial receiver: bit timing defaults,
// character width and the controller state encodings exposed on db_estado.
package rx_serial_7e1_pkg;

  localparam int M_DEFAULT = 434;
  localparam int N_DEFAULT = 9;
  localparam int DATA_W    = 7;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    DATA   = 4'd2,
    PARITY = 4'd3,
    STOP   = 4'd4,
    DONE   = 4'd5
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter used for bit timing; fim flags the last count (M-1).
module contador_m #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] Q,
  output logic         fim
);

  localparam logic [N-1:0] LAST = N'(M - 1);

  logic [N-1:0] r_q;

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      r_q <= '0;
    end else if (zera_s) begin
      r_q <= '0;
    end else if (conta) begin
      r_q <= (r_q == LAST) ? '0 : r_q + 1'b1;
    end
  end

  assign Q   = r_q;
  assign fim = (r_q == LAST);

endmodule

// File: rtl/rx_serial_7e1_fd.sv
// Receiver datapath: line synchroniser, edge detect, bit timing, shift
// register and the held output character with its parity/framing status.
module rx_serial_7e1_fd
  import rx_serial_7e1_pkg::*;
#(
  parameter int M = M_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_dadoSerial,
  input  logic              i_recebeDado,
  input  logic              i_zeraCont,
  input  logic              i_conta,
  input  logic              i_limpaIdx,
  input  logic              i_amostraDado,
  input  logic              i_amostraPar,
  input  logic              i_amostraStop,
  input  logic              i_carrega,
  output logic              o_rx,
  output logic              o_borda,
  output logic              o_meio,
  output logic              o_fim,
  output logic              o_ultimoBit,
  output logic [DATA_W-1:0] o_dados,
  output logic              o_paridadeOk,
  output logic              o_erroFraming,
  output logic              o_temDado
);

  localparam logic [N-1:0] MEIO = N'(M / 2 - 1);

  logic              r_sync1, r_sync2, r_rxPrev;
  logic [N-1:0]      w_q;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_bitIdx;
  logic              r_parBit, r_stopBit;
  logic [DATA_W-1:0] r_dados;
  logic              r_paridadeOk, r_erroFraming, r_temDado;

  // Flops reset to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= i_dadoSerial;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  assign o_rx    = r_sync2;
  assign o_borda = r_rxPrev & ~r_sync2;

  contador_m #(.M(M), .N(N)) u_contador (
    .clock  (clock),
    .zera_as(reset),
    .zera_s (i_zeraCont),
    .conta  (i_conta),
    .Q      (w_q),
    .fim    (o_fim)
  );

  assign o_meio      = (w_q == MEIO);
  assign o_ultimoBit = (r_bitIdx == 3'(DATA_W - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bitIdx  <= '0;
      r_parBit  <= 1'b0;
      r_stopBit <= 1'b0;
    end else begin
      if (i_limpaIdx) r_bitIdx <= '0;
      if (i_amostraDado) begin
        r_shift  <= {r_sync2, r_shift[DATA_W-1:1]};
        r_bitIdx <= r_bitIdx + 3'd1;
      end
      if (i_amostraPar)  r_parBit  <= r_sync2;
      if (i_amostraStop) r_stopBit <= r_sync2;
    end
  end

  // A new character always overwrites; loading wins over a same-cycle acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dados       <= '0;
      r_paridadeOk  <= 1'b0;
      r_erroFraming <= 1'b0;
      r_temDado     <= 1'b0;
    end else if (i_carrega) begin
      r_dados       <= r_shift;
      r_paridadeOk  <= ~^{r_shift, r_parBit};
      r_erroFraming <= ~r_stopBit;
      r_temDado     <= 1'b1;
    end else if (i_recebeDado) begin
      r_temDado     <= 1'b0;
    end
  end

  assign o_dados       = r_dados;
  assign o_paridadeOk  = r_paridadeOk;
  assign o_erroFraming = r_erroFraming;
  assign o_temDado     = r_temDado;

endmodule

// File: rtl/rx_serial_7e1_uc.sv
// Receiver controller: sequences start validation, data, parity and stop
// sampling, and issues the one-cycle load at frame completion.
module rx_serial_7e1_uc
  import rx_serial_7e1_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_borda,
  input  logic       i_rx,
  input  logic       i_meio,
  input  logic       i_fim,
  input  logic       i_ultimoBit,
  output logic       o_zeraCont,
  output logic       o_conta,
  output logic       o_limpaIdx,
  output logic       o_amostraDado,
  output logic       o_amostraPar,
  output logic       o_amostraStop,
  output logic       o_carrega,
  output logic [3:0] o_estado
);

  estado_t r_estado, w_proximo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= IDLE;
    else       r_estado <= w_proximo;
  end

  always_comb begin
    w_proximo     = r_estado;
    o_zeraCont    = 1'b0;
    o_conta       = (r_estado != IDLE);
    o_limpaIdx    = 1'b0;
    o_amostraDado = 1'b0;
    o_amostraPar  = 1'b0;
    o_amostraStop = 1'b0;
    o_carrega     = 1'b0;
    case (r_estado)
      IDLE: if (i_borda) begin
        o_zeraCont = 1'b1;
        w_proximo  = START;
      end
      // A start bit that is high again at mid-bit is a glitch.
      START: if (i_meio) begin
        if (!i_rx) begin
          o_zeraCont = 1'b1;
          o_limpaIdx = 1'b1;
          w_proximo  = DATA;
        end else begin
          w_proximo  = IDLE;
        end
      end
      DATA: if (i_fim) begin
        o_amostraDado = 1'b1;
        o_zeraCont    = 1'b1;
        if (i_ultimoBit) w_proximo = PARITY;
      end
      PARITY: if (i_fim) begin
        o_amostraPar = 1'b1;
        o_zeraCont   = 1'b1;
        w_proximo    = STOP;
      end
      STOP: if (i_fim) begin
        o_amostraStop = 1'b1;
        o_zeraCont    = 1'b1;
        w_proximo     = DONE;
      end
      DONE: begin
        o_carrega = 1'b1;
        w_proximo = IDLE;
      end
      default: w_proximo = IDLE;
    endcase
  end

  assign o_estado = r_estado;

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 UART receiver top: 115200 baud from a 50 MHz clock, with a
// level-valid/acknowledge handshake on the received character.
module rx_serial_7e1
  import rx_serial_7e1_pkg::*;
#(
  parameter int M = M_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dado_serial,
  input  logic              recebe_dado,
  output logic [DATA_W-1:0] dados_ascii,
  output logic              paridade_ok,
  output logic              erro_framing,
  output logic              tem_dado,
  output logic              pronto,
  output logic              db_dado_serial,
  output logic [3:0]        db_estado
);

  logic w_rx, w_borda, w_meio, w_fim, w_ultimoBit;
  logic w_zeraCont, w_conta, w_limpaIdx;
  logic w_amostraDado, w_amostraPar, w_amostraStop, w_carrega;

  rx_serial_7e1_uc u_uc (
    .clock        (clock),
    .reset        (reset),
    .i_borda      (w_borda),
    .i_rx         (w_rx),
    .i_meio       (w_meio),
    .i_fim        (w_fim),
    .i_ultimoBit  (w_ultimoBit),
    .o_zeraCont   (w_zeraCont),
    .o_conta      (w_conta),
    .o_limpaIdx   (w_limpaIdx),
    .o_amostraDado(w_amostraDado),
    .o_amostraPar (w_amostraPar),
    .o_amostraStop(w_amostraStop),
    .o_carrega    (w_carrega),
    .o_estado     (db_estado)
  );

  rx_serial_7e1_fd #(.M(M), .N(N)) u_fd (
    .clock        (clock),
    .reset        (reset),
    .i_dadoSerial (dado_serial),
    .i_recebeDado (recebe_dado),
    .i_zeraCont   (w_zeraCont),
    .i_conta      (w_conta),
    .i_limpaIdx   (w_limpaIdx),
    .i_amostraDado(w_amostraDado),
    .i_amostraPar (w_amostraPar),
    .i_amostraStop(w_amostraStop),
    .i_carrega    (w_carrega),
    .o_rx         (w_rx),
    .o_borda      (w_borda),
    .o_meio       (w_meio),
    .o_fim        (w_fim),
    .o_ultimoBit  (w_ultimoBit),
    .o_dados      (dados_ascii),
    .o_paridadeOk (paridade_ok),
    .o_erroFraming(erro_framing),
    .o_temDado    (tem_dado)
  );

  assign pronto         = w_carrega;
  assign db_dado_serial = w_rx;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Directed bench for rx_serial_7e1: frames are driven bit by bit and a
// scoreboard entry per frame is compared when pronto pulses.
module tb_rx_serial_7e1;

  localparam int M = 434;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dado_serial = 1'b1;
  logic       recebe_dado = 1'b0;
  logic [6:0] dados_ascii;
  logic       paridade_ok, erro_framing, tem_dado, pronto, db_dado_serial;
  logic [3:0] db_estado;

  rx_serial_7e1 dut (
    .clock         (clock),
    .reset         (reset),
    .dado_serial   (dado_serial),
    .recebe_dado   (recebe_dado),
    .dados_ascii   (dados_ascii),
    .paridade_ok   (paridade_ok),
    .erro_framing  (erro_framing),
    .tem_dado      (tem_dado),
    .pronto        (pronto),
    .db_dado_serial(db_dado_serial),
    .db_estado     (db_estado)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [6:0] data;
    logic       parOk;
    logic       erro;
    logic       ackAtDone;
    logic       ackAfter;
    int         startCyc;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   prontoCount = 0;
  int   lat;
  int   pc0;

  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Drives one frame starting at the current negedge and queues its expectation.
  task automatic applyStimulus(input logic [6:0] d, input logic par, input logic stp,
                               input logic ackAtDone, input logic ackAfter);
    exp_t e;
    e.data      = d;
    e.parOk     = (par == ^d);
    e.erro      = ~stp;
    e.ackAtDone = ackAtDone;
    e.ackAfter  = ackAfter;
    e.startCyc  = cyc;
    sb.push_back(e);
    dado_serial = 1'b0;
    repeat (M) @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      dado_serial = d[i];
      repeat (M) @(negedge clock);
    end
    dado_serial = par;
    repeat (M) @(negedge clock);
    dado_serial = stp;
    repeat (M) @(negedge clock);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clock);
    checkOutput(name, 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  // Scoreboard consumer: pops one expectation per pronto pulse.
  always @(negedge clock) begin
    if (pronto === 1'b1) begin
      prontoCount++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("[TB] FAIL unexpected_pronto: observed=pronto expected=no_frame_pending");
      end
      if (sb.size() != 0) begin
        monE = sb.pop_front();
        lat  = cyc - monE.startCyc;
        if (monE.ackAtDone) recebe_dado = 1'b1;
        @(posedge clock);
        #1;
        recebe_dado = 1'b0;
        total++;
        assert (lat >= 4124 && lat <= 4128) else begin
          bad++;
          $error("[TB] FAIL latency: observed=%0d expected=4126", lat);
        end
        checkOutput("dados_ascii", 16'(dados_ascii), 16'(monE.data));
        checkOutput("paridade_ok", 16'(paridade_ok), 16'(monE.parOk));
        checkOutput("erro_framing", 16'(erro_framing), 16'(monE.erro));
        checkOutput("tem_dado_set", 16'(tem_dado), 16'd1);
        checkOutput("pronto_one_cycle", 16'(pronto), 16'd0);
        if (monE.ackAfter) begin
          @(negedge clock);
          recebe_dado = 1'b1;
          @(posedge clock);
          #1;
          recebe_dado = 1'b0;
          checkOutput("tem_dado_ack", 16'(tem_dado), 16'd0);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    checkOutput("rst_dados", 16'(dados_ascii), 16'd0);
    checkOutput("rst_par", 16'(paridade_ok), 16'd0);
    checkOutput("rst_erro", 16'(erro_framing), 16'd0);
    checkOutput("rst_tem", 16'(tem_dado), 16'd0);
    checkOutput("rst_pronto", 16'(pronto), 16'd0);
    checkOutput("rst_estado", 16'(db_estado), 16'd0);
    checkOutput("rst_dbrx", 16'(db_dado_serial), 16'd1);
    reset = 1'b0;
    repeat (20) @(negedge clock);

    $display("[TB] frame 'A'");
    applyStimulus(7'h41, 1'b0, 1'b1, 1'b0, 1'b0);
    waitDrain("drain_A");

    $display("[TB] frame 'C' with wrong parity, acknowledged afterwards");
    applyStimulus(7'h43, 1'b0, 1'b1, 1'b0, 1'b1);
    waitDrain("drain_C");

    $display("[TB] glitch");
    pc0 = prontoCount;
    dado_serial = 1'b0;
    repeat (50) @(negedge clock);
    checkOutput("glitch_in_start", 16'(db_estado), 16'd1);
    repeat (50) @(negedge clock);
    dado_serial = 1'b1;
    repeat (300) @(negedge clock);
    checkOutput("glitch_idle", 16'(db_estado), 16'd0);
    checkOutput("glitch_no_pronto", 16'(prontoCount), 16'(pc0));
    checkOutput("glitch_dados", 16'(dados_ascii), 16'h43);
    checkOutput("glitch_par", 16'(paridade_ok), 16'd0);
    checkOutput("glitch_tem", 16'(tem_dado), 16'd0);

    $display("[TB] 0x55 with stop bit 0, line held low");
    applyStimulus(7'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain("drain_55");
    pc0 = prontoCount;
    repeat (800) @(negedge clock);
    checkOutput("stuck_low_idle", 16'(db_estado), 16'd0);
    checkOutput("stuck_low_no_pronto", 16'(prontoCount), 16'(pc0));
    dado_serial = 1'b1;
    repeat (500) @(negedge clock);
    applyStimulus(7'h41, 1'b0, 1'b1, 1'b0, 1'b0);
    waitDrain("drain_A2");

    $display("[TB] back-to-back 0x41 then 0x5A, ack with second DONE");
    repeat (100) @(negedge clock);
    applyStimulus(7'h41, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    waitDrain("drain_b2b");
    checkOutput("b2b_tem", 16'(tem_dado), 16'd1);
    checkOutput("b2b_dados", 16'(dados_ascii), 16'h5A);

    $display("[TB] reset during DATA");
    repeat (100) @(negedge clock);
    dado_serial = 1'b0;
    repeat (M) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      dado_serial = (i == 4);
      repeat (M) @(negedge clock);
    end
    checkOutput("mid_data_state", 16'(db_estado), 16'd2);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_dados", 16'(dados_ascii), 16'd0);
    checkOutput("mid_rst_tem", 16'(tem_dado), 16'd0);
    checkOutput("mid_rst_par", 16'(paridade_ok), 16'd0);
    checkOutput("mid_rst_estado", 16'(db_estado), 16'd0);
    @(negedge clock);
    reset = 1'b0;
    dado_serial = 1'b1;
    pc0 = prontoCount;
    repeat (1000) @(negedge clock);
    checkOutput("post_rst_idle", 16'(db_estado), 16'd0);
    checkOutput("post_rst_no_pronto", 16'(prontoCount), 16'(pc0));
    applyStimulus(7'h30, 1'b0, 1'b1, 1'b0, 1'b0);
    waitDrain("drain_30");
    checkOutput("total_pronto", 16'(prontoCount), 16'd7);

    repeat (10) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_serial_7e1.md
Name: rx_serial_7E1

Overview:
- UART receiver for 7E1 frames: 1 start bit, 7 data bits LSB first, even parity, 1 stop bit, at 115200 baud from a 50 MHz clock.
- Sits directly downstream of the 7E1 transmitter, typically looped back or attached to the opposite end of the serial line.
- Deserialises the frame, checks parity and the stop bit, and presents the ASCII character with a level-valid/acknowledge handshake.

Parameters:
- M, 434, clock cycles per bit (50 MHz / 115200).
- N, 9, width of the bit-timing counter (2^N > M).

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- dado_serial  in  1  serial line, idle high, asynchronous to clock
- recebe_dado  in  1  consumer acknowledge; clears tem_dado
- dados_ascii  out  7  last received character
- paridade_ok  out  1  1 = received parity bit makes total ones count even
- erro_framing  out  1  1 = stop bit of last frame sampled as 0
- tem_dado  out  1  level, 1 = unread character held in dados_ascii
- pronto  out  1  one-cycle pulse at frame completion
- db_dado_serial  out  1  synchronised serial line (debug)
- db_estado  out  4  state encoding (debug)

Behaviour:
- Reset (async, active-high):
  - state IDLE; dados_ascii = 0; paridade_ok = 0; erro_framing = 0; tem_dado = 0; pronto = 0.
  - Both synchroniser flops reset to 1 (idle line level).
- Input synchronisation: 2-flop synchroniser on dado_serial, giving 2 cycles of latency. All decisions use the synchronised signal s_rx.
- States and db_estado encodings:
  - IDLE = 0
  - START = 1
  - DATA = 2
  - PARITY = 3
  - STOP = 4
  - DONE = 5
  - Unused codes return to IDLE.
- IDLE:
  - Falling edge on s_rx (previous 1, current 0) zeroes the bit counter and enters START.
  - A line stuck at 0 does not re-trigger; a high level must be seen first.
- START:
  - At count M/2-1 (217 cycles after the edge), sample s_rx.
  - If 0: zero the counter, bit index = 0, enter DATA.
  - If 1: treat as a glitch, return to IDLE, no outputs change.
- DATA:
  - Every M cycles, sample s_rx into a shift register (LSB first).
  - After the 7th sample, enter PARITY.
- PARITY: after M cycles, sample the parity bit and enter STOP.
- STOP: after M cycles, sample the stop bit and enter DONE.
  - Stop-bit sample occurs 217 + 9*434 = 4123 cycles after start-edge detection.
- DONE, exactly 1 cycle:
  - Load dados_ascii from the shift register.
  - paridade_ok = ~^(data XOR parity), i.e. 1 when data plus parity has even parity.
  - erro_framing = ~stop_bit.
  - pronto = 1 and tem_dado = 1.
  - Next state IDLE.
  - Data is delivered even when parity or framing is bad.
- tem_dado:
  - Set in DONE.
  - Cleared on the cycle after recebe_dado = 1.
  - If DONE and recebe_dado coincide, the set wins and tem_dado stays 1.
  - A new frame overwrites dados_ascii even if tem_dado = 1; there is no overrun flag.
- Output stability: dados_ascii, paridade_ok and erro_framing hold their values until the next DONE or reset.
- Reset mid-frame: immediate return to IDLE with all outputs cleared. The remainder of an in-flight frame is ignored until the next falling edge.
- Bit counter: contador_m instance with M/N parameters.
  - Zeroed synchronously on entry to START and at each sample point.
  - Counts only outside IDLE.
  - Wrap-around at M-1 is the sample tick.
  - The half-bit tick uses a comparison against M/2-1 on the counter output Q.

Decomposition:
- Shared header (rx_serial_defs): state encodings, M/2 offset, data width (7).
- Sub-modules:
  - rx_serial_7E1_fd: synchroniser, edge detect, shift register, bit index counter, output registers, parity/stop checks.
  - rx_serial_uc: FSM only.
- Bit timing reuses the existing contador_m; no new counter module.

Test Plan:
- 'A' (0x41): frame 0,1,0,0,0,0,0,1,parity 0,stop 1 at 434 cycles/bit. Expect pronto pulse ~4124 cycles after edge, dados_ascii = 0x41, paridade_ok = 1, erro_framing = 0, tem_dado = 1.
- 'C' (0x43) sent with wrong parity bit 0. Expect dados_ascii = 0x43, paridade_ok = 0.
- Glitch: line low for 100 cycles, then high. Expect state back to IDLE, no pronto, outputs unchanged.
- Stop bit forced 0 on 0x55 (parity 0). Expect dados_ascii = 0x55, erro_framing = 1. Then after line high, a clean 0x41 is received correctly with erro_framing = 0.
- Back-to-back 0x41 then 0x5A with no idle gap; recebe_dado pulsed in the same cycle as the second DONE. Expect two pronto pulses, final dados_ascii = 0x5A, tem_dado = 1.
- Reset asserted mid-DATA. Expect all outputs 0 and IDLE immediately. The next full frame 0x30 is received correctly.
